// File: rtl/mmio_button_reader_if.sv
// mmio_button_reader_if
//   CPU-side load/store bus for the button reader peripheral.
//   master : CPU (drives m_addr/rea/wea/m_data, receives rdata/rvalid[/irq])
//   slave  : peripheral
//   Signals:
//     m_addr [31:0]  byte address shared with the LED store decoder
//     rea            read strobe, one cycle per load
//     wea            write strobe
//     m_data [31:0]  write data
//     rdata  [31:0]  read data, valid while rvalid=1, held otherwise
//     rvalid         one-cycle pulse one clock after an accepted read
//     irq            interrupt request, only present when BTN_IRQ_EN is defined
interface mmio_button_reader_if;
  logic [31:0] m_addr;
  logic        rea;
  logic        wea;
  logic [31:0] m_data;
  logic [31:0] rdata;
  logic        rvalid;
`ifdef BTN_IRQ_EN
  logic        irq;

  modport master (output m_addr, rea, wea, m_data, input rdata, rvalid, irq);
  modport slave  (input m_addr, rea, wea, m_data, output rdata, rvalid, irq);
`else
  modport master (output m_addr, rea, wea, m_data, input rdata, rvalid);
  modport slave  (input m_addr, rea, wea, m_data, output rdata, rvalid);
`endif
endinterface

// File: rtl/mmio_button_reader.sv
// mmio_button_reader
//   Memory-mapped push-button input peripheral. Each raw button goes through a
//   2-flop synchronizer and a stable-count debouncer; the debounced levels,
//   sticky rising-edge flags (clear-on-read) and a press counter are readable
//   over the CPU load bus.
//   Register map (byte offsets from BASE_ADDR, unused bits read 0):
//     0x0 LEVEL  debounced levels, read-only
//     0x4 FLAGS  sticky rising-edge flags, cleared by a read
//     0x8 COUNT  press counter (wraps), read-only
//     0xC MASK   irq mask when BTN_IRQ_EN is defined, otherwise reads 0
//   Ports:
//     clk       system clock
//     rst       asynchronous reset, active low
//     btn       raw asynchronous button levels [N_BTN-1:0]
//     bus       mmio_button_reader_if.slave (m_addr/rea/wea/m_data in,
//               rdata/rvalid out, irq out when BTN_IRQ_EN)
//   Optional feature macro: BTN_IRQ_EN (MASK register + registered irq).

// Per-button lane: synchronizer plus debouncer. level_o moves to the
// synchronized value once it has disagreed for DEBOUNCE_CYCLES consecutive
// cycles; rise_o flags the cycle in which level_o is about to go 0->1.
module mmio_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_btn;

  assign sync_btn = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle that agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_o  = 1'b0;
    if (sync_btn != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_btn;
        rise_o  = sync_btn;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
endmodule

module mmio_button_reader #(
  parameter logic [31:0] BASE_ADDR       = 32'h3100,
  parameter int          N_BTN           = 8,
  parameter int          DEBOUNCE_CYCLES = 1000,
  parameter int          CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn,
  mmio_button_reader_if.slave bus
);
  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_FLAGS = 2'd1,
    REG_COUNT = 2'd2,
    REG_MASK  = 2'd3
  } reg_sel_e;

  logic [N_BTN-1:0] level, rise;
  logic [N_BTN-1:0] flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d, rd_val;
  logic             rvalid_q, rvalid_d;
  logic [N_BTN-1:0] mask_q;
  logic [31:0]      off;
  logic             hit, rd_acc;
  reg_sel_e         sel;
  logic             unused_bus;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    mmio_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn[i]),
      .level_o(level[i]),
      .rise_o (rise[i])
    );
  end

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_BTN-1:0] v);
    popcnt = '0;
    for (int i = 0; i < N_BTN; i++) popcnt = popcnt + CNT_W'(v[i]);
  endfunction

  // Offset trick: addresses below BASE wrap to huge offsets and fail the
  // upper-bits test, so one compare covers both range ends.
  assign off    = bus.m_addr - BASE_ADDR;
  assign hit    = (off[31:4] == 28'd0) && (off[1:0] == 2'd0);
  assign sel    = reg_sel_e'(off[3:2]);
  assign rd_acc = bus.rea && hit;

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_LEVEL: rd_val[N_BTN-1:0] = level;
      REG_FLAGS: rd_val[N_BTN-1:0] = flag_q;
      REG_COUNT: rd_val[CNT_W-1:0] = cnt_q;
      REG_MASK:  rd_val[N_BTN-1:0] = mask_q;
      default:   rd_val = '0;
    endcase
  end

  // Clear first, then OR the new rises so a same-cycle edge survives the read.
  always_comb begin
    flag_d = flag_q;
    if (rd_acc && sel == REG_FLAGS) flag_d = '0;
    flag_d   = flag_d | rise;
    cnt_d    = cnt_q + popcnt(rise);
    rvalid_d = rd_acc;
    rdata_d  = rd_acc ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  // Only the low N_BTN bits of write data matter, and only for MASK.
  assign unused_bus = ^{bus.wea, bus.m_data};

`ifdef BTN_IRQ_EN
  logic [N_BTN-1:0] mask_d;
  logic             irq_q, irq_d;
  logic             wr_mask;

  assign wr_mask = bus.wea && hit && (sel == REG_MASK);

  always_comb begin
    mask_d = wr_mask ? bus.m_data[N_BTN-1:0] : mask_q;
    irq_d  = |(flag_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  assign mask_q = '0;
`endif
endmodule

// File: tb/tb_mmio_button_reader.sv
`timescale 1ns/1ps
module tb_mmio_button_reader;
  localparam logic [31:0] BASE = 32'h3100;
  localparam int NB = 8;
  localparam int DC = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn = '0;
  int errors = 0;
  int checks = 0;

  mmio_button_reader_if bus();

  mmio_button_reader #(.BASE_ADDR(BASE), .N_BTN(NB), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .btn(btn), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: a bit's level flips once its last DC synchronized
  // samples (raw samples 2..DC+1 edges old) all disagree with it.
  logic [NB-1:0] hist   [0:DC+1];
  logic [NB-1:0] n_hist [0:DC+1];
  logic [NB-1:0] m_level, m_flags, m_mask, n_level, n_flags, n_mask, m_rise;
  logic [CW-1:0] m_cnt, n_cnt;
  logic [31:0]   m_rdata, n_rdata, m_off;
  logic          m_rvalid, n_rvalid, m_acc, stable;
`ifdef BTN_IRQ_EN
  logic          m_irq, n_irq;
`endif

  always_comb begin
    n_hist[0] = btn;
    for (int j = 1; j <= DC + 1; j++) n_hist[j] = hist[j-1];
    n_level = m_level;
    stable  = 1'b0;
    for (int b = 0; b < NB; b++) begin
      stable = 1'b1;
      for (int j = 2; j <= DC + 1; j++) if (n_hist[j][b] == m_level[b]) stable = 1'b0;
      if (stable) n_level[b] = ~m_level[b];
    end
    m_rise   = n_level & ~m_level;
    m_off    = bus.m_addr - BASE;
    m_acc    = bus.rea && (m_off < 32'd16) && (m_off[1:0] == 2'b00);
    n_rvalid = m_acc;
    n_rdata  = m_rdata;
    if (m_acc) begin
      if (m_off == 32'd0)      n_rdata = {24'h0, m_level};
      else if (m_off == 32'd4) n_rdata = {24'h0, m_flags};
      else if (m_off == 32'd8) n_rdata = {28'h0, m_cnt};
      else                     n_rdata = {24'h0, m_mask};
    end
    n_flags = (m_acc && m_off == 32'd4) ? m_rise : (m_flags | m_rise);
    n_cnt   = m_cnt + CW'($countones(m_rise));
    n_mask  = m_mask;
`ifdef BTN_IRQ_EN
    if (bus.wea && bus.m_addr == BASE + 32'd12) n_mask = bus.m_data[NB-1:0];
    n_irq = |(m_flags & m_mask);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j <= DC + 1; j++) hist[j] <= '0;
      m_level <= '0; m_flags <= '0; m_mask <= '0; m_cnt <= '0;
      m_rdata <= '0; m_rvalid <= 1'b0;
`ifdef BTN_IRQ_EN
      m_irq <= 1'b0;
`endif
    end else begin
      for (int j = 0; j <= DC + 1; j++) hist[j] <= n_hist[j];
      m_level <= n_level; m_flags <= n_flags; m_mask <= n_mask; m_cnt <= n_cnt;
      m_rdata <= n_rdata; m_rvalid <= n_rvalid;
`ifdef BTN_IRQ_EN
      m_irq <= n_irq;
`endif
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a);
    bus.m_addr = a; bus.rea = 1'b1;
    @(negedge clk);
    bus.rea = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.m_addr = a; bus.m_data = d; bus.wea = 1'b1;
    @(negedge clk);
    bus.wea = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn = 8'hFF;
    wait_cyc(3);
    checks++; if ({bus.rvalid, bus.rdata} !== 33'h0) begin errors++; $display("FAIL reset_out: got %b/%h want 0/00000000", bus.rvalid, bus.rdata); end
`ifdef BTN_IRQ_EN
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
`endif
    rst = 1'b1;
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reset_level: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
    do_read(BASE + 4);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reset_flags: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
    do_read(BASE + 8);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reset_count: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
    wait_cyc(6);
    // accepted on the edge where level changes: shows the old value
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL settle_edge_level: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'hFF}) begin errors++; $display("FAIL settled_level: got %b/%h want 1/000000ff", bus.rvalid, bus.rdata); end
    do_read(BASE + 4);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'hFF}) begin errors++; $display("FAIL settled_flags: got %b/%h want 1/000000ff", bus.rvalid, bus.rdata); end
    do_read(BASE + 8);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h8}) begin errors++; $display("FAIL settled_count: got %b/%h want 1/00000008", bus.rvalid, bus.rdata); end
    do_read(BASE + 12);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL reset_mask: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
  endtask

  task automatic test_bounce();
    btn = 8'h00; wait_cyc(DC + 4);
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL level_fall: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
    btn = 8'h01; wait_cyc(5); btn = 8'h00; wait_cyc(DC + 6);
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL bounce_reject: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
    btn = 8'h01; wait_cyc(9);
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL bounce_edge_early: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL bounce_edge: got %b/%h want 1/00000001", bus.rvalid, bus.rdata); end
    do_read(BASE + 4);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL bounce_flags: got %b/%h want 1/00000001", bus.rvalid, bus.rdata); end
    do_read(BASE + 8);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h9}) begin errors++; $display("FAIL bounce_count: got %b/%h want 1/00000009", bus.rvalid, bus.rdata); end
  endtask

  task automatic test_handshake();
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL hs_level: got %b/%h want 1/00000001", bus.rvalid, bus.rdata); end
    wait_cyc(1);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b0, 32'h1}) begin errors++; $display("FAIL hs_pulse_hold: got %b/%h want 0/00000001", bus.rvalid, bus.rdata); end
    do_read(BASE + 2);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b0, 32'h1}) begin errors++; $display("FAIL hs_misaligned: got %b/%h want 0/00000001", bus.rvalid, bus.rdata); end
    do_read(32'h3200);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b0, 32'h1}) begin errors++; $display("FAIL hs_unmapped: got %b/%h want 0/00000001", bus.rvalid, bus.rdata); end
    do_read(BASE - 4);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b0, 32'h1}) begin errors++; $display("FAIL hs_below: got %b/%h want 0/00000001", bus.rvalid, bus.rdata); end
    do_read(BASE + 16);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b0, 32'h1}) begin errors++; $display("FAIL hs_above: got %b/%h want 0/00000001", bus.rvalid, bus.rdata); end
    // back-to-back
    do_read(BASE + 8);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h9}) begin errors++; $display("FAIL b2b_0: got %b/%h want 1/00000009", bus.rvalid, bus.rdata); end
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL b2b_1: got %b/%h want 1/00000001", bus.rvalid, bus.rdata); end
    do_read(BASE + 8);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h9}) begin errors++; $display("FAIL b2b_2: got %b/%h want 1/00000009", bus.rvalid, bus.rdata); end
    // writes to read-only registers are ignored
    do_write(BASE, 32'hFF);
    do_write(BASE + 8, 32'h0);
    bus.m_addr = BASE + 8; bus.m_data = 32'h3; bus.rea = 1'b1; bus.wea = 1'b1;
    @(negedge clk);
    bus.rea = 1'b0; bus.wea = 1'b0;
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h9}) begin errors++; $display("FAIL rd_wr_count: got %b/%h want 1/00000009", bus.rvalid, bus.rdata); end
    do_read(BASE);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL wr_ignored_level: got %b/%h want 1/00000001", bus.rvalid, bus.rdata); end
  endtask

  task automatic test_race();
    btn = 8'h09; wait_cyc(DC + 4);
    btn = 8'h29; wait_cyc(9);
    do_read(BASE + 4);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h08}) begin errors++; $display("FAIL race_first: got %b/%h want 1/00000008", bus.rvalid, bus.rdata); end
    do_read(BASE + 4);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h20}) begin errors++; $display("FAIL race_second: got %b/%h want 1/00000020", bus.rvalid, bus.rdata); end
    do_read(BASE + 8);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'hB}) begin errors++; $display("FAIL race_count: got %b/%h want 1/0000000b", bus.rvalid, bus.rdata); end
  endtask

  task automatic test_wrap();
    do_read(BASE);
    rst = 1'b0; btn = 8'h00;
    #1;
    checks++; if ({bus.rvalid, bus.rdata} !== 33'h0) begin errors++; $display("FAIL reset_midop: got %b/%h want 0/00000000", bus.rvalid, bus.rdata); end
    wait_cyc(2);
    rst = 1'b1;
    do_read(BASE + 8);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_start: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
    for (int k = 0; k < 17; k++) begin
      btn = 8'h02; wait_cyc(DC + 3);
      btn = 8'h00; wait_cyc(DC + 3);
    end
    do_read(BASE + 8);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL wrap_count: got %b/%h want 1/00000001", bus.rvalid, bus.rdata); end
    do_read(BASE + 4);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h2}) begin errors++; $display("FAIL wrap_flags: got %b/%h want 1/00000002", bus.rvalid, bus.rdata); end
  endtask

`ifdef BTN_IRQ_EN
  task automatic test_irq();
    do_write(BASE + 12, 32'hFFFF_FF04);
    do_read(BASE + 12);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h4}) begin errors++; $display("FAIL mask_read: got %b/%h want 1/00000004", bus.rvalid, bus.rdata); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", bus.irq); end
    btn = 8'h04; wait_cyc(DC + 4);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", bus.irq); end
    do_read(BASE + 4);
    checks++; if ({bus.irq, bus.rvalid, bus.rdata} !== {2'b11, 32'h4}) begin errors++; $display("FAIL irq_read: got %b/%b/%h want 1/1/00000004", bus.irq, bus.rvalid, bus.rdata); end
    wait_cyc(1);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", bus.irq); end
    btn = 8'h00; wait_cyc(DC + 4);
    btn = 8'h01; wait_cyc(DC + 4);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b want 0", bus.irq); end
    do_read(BASE + 4);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h1}) begin errors++; $display("FAIL irq_masked_flags: got %b/%h want 1/00000001", bus.rvalid, bus.rdata); end
  endtask
`else
  task automatic test_mask_absent();
    do_write(BASE + 12, 32'hFF);
    do_read(BASE + 12);
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mask_absent: got %b/%h want 1/00000000", bus.rvalid, bus.rdata); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) btn = NB'($urandom);
      else if ($urandom_range(0, 11) == 0) btn = btn ^ (NB'(1) << $urandom_range(0, NB - 1));
      bus.rea = ($urandom_range(0, 2) == 0);
      bus.wea = ($urandom_range(0, 9) == 0);
      bus.m_data = $urandom;
      case ($urandom_range(0, 7))
        0, 1, 2, 3: bus.m_addr = BASE + 32'($urandom_range(0, 3)) * 4;
        4:          bus.m_addr = BASE + 32'($urandom_range(1, 3));
        5:          bus.m_addr = BASE + 16;
        6:          bus.m_addr = BASE - 4;
        default:    bus.m_addr = $urandom;
      endcase
      @(negedge clk);
      checks++; if ({bus.rvalid, bus.rdata} !== {m_rvalid, m_rdata}) begin errors++; $display("FAIL rand_read[%0d]: got %b/%h want %b/%h", c, bus.rvalid, bus.rdata, m_rvalid, m_rdata); end
`ifdef BTN_IRQ_EN
      checks++; if (bus.irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b want %b", c, bus.irq, m_irq); end
`endif
    end
    bus.rea = 1'b0; bus.wea = 1'b0;
  endtask

  initial begin
    bus.m_addr = '0; bus.rea = 1'b0; bus.wea = 1'b0; bus.m_data = '0;
    test_reset();
    test_bounce();
    test_handshake();
    test_race();
    test_wrap();
`ifdef BTN_IRQ_EN
    test_irq();
`else
    test_mask_absent();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, want finish before 2ms");
    $fatal(1);
  end
endmodule
